// File: rtl/router_pkg.sv
// Shared definitions for the router: byte/address widths, destination codes and
// the control FSM state encoding used by router_reg and the FSM.
package router_pkg;

    localparam int ROUTER_DATA_W = 8;
    localparam int ROUTER_ADDR_W = 2;

    typedef enum logic [ROUTER_ADDR_W-1:0] {
        DEST_0 = 2'b00,
        DEST_1 = 2'b01,
        DEST_2 = 2'b10
    } dest_e;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

endpackage

// File: rtl/router_parity_chk.sv
// Running packet parity, captured trailing parity byte and the sticky mismatch flag.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              pkt_valid,
    input  logic              parity_done,
    input  logic [DATA_W-1:0] hdr_byte,
    input  logic [DATA_W-1:0] data_in,
    output logic              err
);

    logic [DATA_W-1:0] int_parity;
    logic [DATA_W-1:0] pkt_parity;

    // The trailing parity byte (pkt_valid low) is captured but never folded in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_parity <= '0;
        end else if (detect_add) begin
            int_parity <= '0;
        end else if (lfd_state) begin
            int_parity <= int_parity ^ hdr_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            int_parity <= int_parity ^ data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pkt_parity <= '0;
        end else if (detect_add) begin
            pkt_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            pkt_parity <= data_in;
        end
    end

    // Compared one clock after parity_done so both operands are settled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (detect_add) begin
            err <= 1'b0;
        end else if (parity_done && (pkt_parity != int_parity)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/router_reg.sv
// Router datapath register stage: header/payload capture, full-FIFO hold byte,
// parity tracking. Define ROUTER_REG_ERR_CNT_EN to add the saturating err_cnt output.
module router_reg
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
`ifdef ROUTER_REG_ERR_CNT_EN
    output logic [7:0]        err_cnt,
`endif
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] hdr_byte;
    logic [DATA_W-1:0] hold_byte;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_byte <= '0;
        end else if (detect_add && pkt_valid) begin
            hdr_byte <= data_in;
        end
    end

    // A byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout      <= '0;
            hold_byte <= '0;
        end else if (lfd_state) begin
            dout <= hdr_byte;
        end else if (ld_state && !fifo_full) begin
            dout <= data_in;
        end else if (ld_state && fifo_full) begin
            hold_byte <= data_in;
        end else if (laf_state) begin
            dout <= hold_byte;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    router_parity_chk #(
        .DATA_W (DATA_W)
    ) u_parity_chk (
        .clock       (clock),
        .reset       (reset),
        .detect_add  (detect_add),
        .lfd_state   (lfd_state),
        .ld_state    (ld_state),
        .full_state  (full_state),
        .pkt_valid   (pkt_valid),
        .parity_done (parity_done),
        .hdr_byte    (hdr_byte),
        .data_in     (data_in),
        .err         (err)
    );

`ifdef ROUTER_REG_ERR_CNT_EN
    logic err_q;

    // Counts rising edges of err, saturating instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            err_q <= err;
            if (err && !err_q && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: the bench plays the control FSM and source,
// and predicts the dout byte stream and parity verdict per packet.
module tb_router_reg;
    import router_pkg::*;

    localparam int W = ROUTER_DATA_W;

    logic         clock = 1'b0;
    logic         reset;
    logic         pkt_valid;
    logic [W-1:0] data_in;
    logic         fifo_full;
    logic         detect_add;
    logic         lfd_state;
    logic         ld_state;
    logic         laf_state;
    logic         full_state;
    logic         rst_int_reg;
    logic         parity_done;
    logic         low_pkt_valid;
    logic         err;
    logic [W-1:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
    logic [7:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Packet under construction: payload bytes and, per byte, the number of
    // FIFO_FULL_STATE cycles that follow it (0 = FIFO not full for that byte).
    logic [W-1:0] pl_q[$];
    int           full_q[$];

    router_reg dut (
        .clock         (clock),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err),
`ifdef ROUTER_REG_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .dout          (dout)
    );

    always #5 clock = ~clock;

    task automatic idle_inputs();
        pkt_valid   = 1'b0;
        data_in     = '0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        lfd_state   = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        rst_int_reg = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // FIFO_FULL_STATE for n cycles (stray source data must be ignored), then LOAD_AFTER_FULL.
    task automatic run_full(input int n, input logic [W-1:0] held, input logic pv, input string tag);
        for (int k = 0; k < n; k++) begin
            idle_inputs();
            full_state = 1'b1;
            fifo_full  = 1'b1;
            pkt_valid  = pv;
            data_in    = W'($urandom);
            tick();
            checks++;
            if (dout !== held) begin
                errors++;
                $display("FAIL %s_full_hold: dout got %h expected %h", tag, dout, held);
            end
        end
        idle_inputs();
        laf_state = 1'b1;
        pkt_valid = pv;
        data_in   = W'($urandom);
        tick();
    endtask

    // Drives one packet built from pl_q/full_q and checks the output stream.
    task automatic send_packet(input logic [W-1:0] hdr, input logic [W-1:0] par,
                               input int par_full, output bit exp_err);
        logic [W-1:0] exp_par;
        logic [W-1:0] prev;
        exp_par = hdr;
        foreach (pl_q[i]) exp_par = exp_par ^ pl_q[i];
        exp_err = (par != exp_par);

        idle_inputs();
        detect_add = 1'b1;
        pkt_valid  = 1'b1;
        data_in    = hdr;
        tick();
        checks++;
        if (err !== 1'b0 || parity_done !== 1'b0) begin
            errors++;
            $display("FAIL decode_clear: err/parity_done got %b%b expected 00", err, parity_done);
        end

        idle_inputs();
        lfd_state = 1'b1;
        pkt_valid = 1'b1;
        data_in   = pl_q[0];
        tick();
        checks++;
        if (dout !== hdr) begin
            errors++;
            $display("FAIL header_out: dout got %h expected %h", dout, hdr);
        end
        prev = hdr;

        foreach (pl_q[i]) begin
            idle_inputs();
            ld_state  = 1'b1;
            pkt_valid = 1'b1;
            data_in   = pl_q[i];
            fifo_full = (full_q[i] != 0);
            tick();
            if (full_q[i] == 0) begin
                checks++;
                if (dout !== pl_q[i]) begin
                    errors++;
                    $display("FAIL payload_out[%0d]: dout got %h expected %h", i, dout, pl_q[i]);
                end
            end else begin
                checks++;
                if (dout !== prev) begin
                    errors++;
                    $display("FAIL payload_held[%0d]: dout got %h expected %h", i, dout, prev);
                end
                run_full(full_q[i], prev, 1'b1, "payload");
                checks++;
                if (dout !== pl_q[i]) begin
                    errors++;
                    $display("FAIL payload_laf[%0d]: dout got %h expected %h", i, dout, pl_q[i]);
                end
            end
            prev = pl_q[i];
        end

        idle_inputs();
        ld_state  = 1'b1;
        pkt_valid = 1'b0;
        data_in   = par;
        fifo_full = (par_full != 0);
        tick();
        checks++;
        if (low_pkt_valid !== 1'b1) begin
            errors++;
            $display("FAIL low_pkt_valid_set: got %b expected 1", low_pkt_valid);
        end
        if (par_full != 0) begin
            checks++;
            if (parity_done !== 1'b0 || dout !== prev) begin
                errors++;
                $display("FAIL parity_held: parity_done/dout got %b/%h expected 0/%h",
                         parity_done, dout, prev);
            end
            run_full(par_full, prev, 1'b0, "parity");
        end
        checks++;
        if (dout !== par || parity_done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL parity_out: dout/parity_done/err got %h/%b/%b expected %h/1/0",
                     dout, parity_done, err, par);
        end

        idle_inputs();
        rst_int_reg = 1'b1;
        tick();
        checks++;
        if (err !== exp_err || low_pkt_valid !== 1'b0 || parity_done !== 1'b1) begin
            errors++;
            $display("FAIL check_parity: err/low_pkt_valid/parity_done got %b/%b/%b expected %b/0/1",
                     err, low_pkt_valid, parity_done, exp_err);
        end

        idle_inputs();
        tick();
    endtask

    task automatic set_basic_packet();
        pl_q   = {8'h11, 8'h22, 8'h33};
        full_q = {0, 0, 0};
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        checks++;
        if (dout !== '0 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dout/pd/lpv/err got %h/%b/%b/%b expected 00/0/0/0",
                     dout, parity_done, low_pkt_valid, err);
        end
`ifdef ROUTER_REG_ERR_CNT_EN
        checks++;
        if (err_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_err_cnt: got %h expected 00", err_cnt);
        end
`endif
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (dout !== '0 || parity_done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: dout/pd got %h/%b expected 00/0", dout, parity_done);
        end
    endtask

    task automatic test_good_packet();
        bit e;
        set_basic_packet();
        send_packet(8'h0D, 8'h0D, 0, e);
    endtask

    task automatic test_bad_parity();
        bit e;
        set_basic_packet();
        send_packet(8'h0D, 8'hFF, 0, e);
        // The next packet's detect_add must clear the sticky err.
        set_basic_packet();
        send_packet(8'h0D, 8'h0D, 0, e);
    endtask

    task automatic test_full_payload();
        bit e;
        pl_q   = {8'h11, 8'h22, 8'h33};
        full_q = {0, 2, 0};
        send_packet(8'h0D, 8'h0D, 0, e);
    endtask

    task automatic test_full_parity();
        bit e;
        set_basic_packet();
        send_packet(8'h0D, 8'h0D, 2, e);
    endtask

    task automatic test_async_reset();
        bit e;
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick();
        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11; tick();
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11; tick();
        data_in = 8'h22; tick();
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dout !== '0 || parity_done !== 1'b0 || low_pkt_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: dout/pd/lpv/err got %h/%b/%b/%b expected 00/0/0/0",
                     dout, parity_done, low_pkt_valid, err);
        end
        #1 reset = 1'b0;
        idle_inputs();
        tick();
        set_basic_packet();
        send_packet(8'h0D, 8'h0D, 0, e);
    endtask

    task automatic test_random();
        bit e;
        logic [W-1:0] hdr;
        logic [W-1:0] par;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(1, 6));
            pl_q.delete();
            full_q.delete();
            hdr = W'($urandom);
            par = hdr;
            for (int i = 0; i < len; i++) begin
                pl_q.push_back(W'($urandom));
                par = par ^ pl_q[i];
                full_q.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
            end
            if ($urandom_range(0, 1) == 1) par = par ^ W'($urandom_range(1, 255));
            send_packet(hdr, par, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, e);
        end
    endtask

`ifdef ROUTER_REG_ERR_CNT_EN
    task automatic test_err_cnt();
        bit e;
        int bad_seen;
        logic [W-1:0] hdr;
        reset = 1'b1;
        #2 reset = 1'b0;
        idle_inputs();
        tick();
        bad_seen = 0;
        for (int p = 0; p < 300; p++) begin
            hdr    = W'($urandom);
            pl_q   = {W'($urandom)};
            full_q = {0};
            send_packet(hdr, hdr ^ pl_q[0] ^ 8'h5A, 0, e);
            bad_seen++;
            checks++;
            if (err_cnt !== 8'((bad_seen > 255) ? 255 : bad_seen)) begin
                errors++;
                $display("FAIL err_cnt[%0d]: got %h expected %h", p, err_cnt,
                         8'((bad_seen > 255) ? 255 : bad_seen));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_full_payload();
        test_full_parity();
        test_async_reset();
        test_random();
`ifdef ROUTER_REG_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
